// File: rtl/srm_icache.sv
// Direct-mapped read-only instruction cache with line fill and store snooping.
// Optional SRM_ICACHE_FLUSH_EN adds a flush input that clears every line and aborts a fill.
module srm_icache #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              Res,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] dw_addr,
  input  logic [31:0]       din,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
`ifdef SRM_ICACHE_FLUSH_EN
  input  logic              flush,
`endif
  output logic [ADDR_W-1:0] addr_out,
  output logic [31:0]       dout,
  output logic              fetch
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned LB    = 2 + OFF_W;
  localparam int unsigned TAG_W = ADDR_W - LB - IDX_W;

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              kill_q, kill_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES*LINE_WORDS];

  logic [ADDR_W-1:0] la;
  logic [OFF_W-1:0]  la_off;
  logic [IDX_W-1:0]  la_idx, st_idx, fill_idx;
  logic [TAG_W-1:0]  la_tag, st_tag, fill_tag;
  logic              flush_c, hit_c, miss_start_c, store_fill_c;
  logic              wr_en, tag_wr;
  logic [IDX_W-1:0]  wr_idx;
  logic [OFF_W-1:0]  wr_word;
  logic              unused_c;

`ifdef SRM_ICACHE_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Lookup decode and combinational hit path
  always_comb begin
    la           = jmp ? jmp_addr : addr;
    la_off       = la[2 +: OFF_W];
    la_idx       = la[LB +: IDX_W];
    la_tag       = la[LB+IDX_W +: TAG_W];
    st_idx       = dw_addr[LB +: IDX_W];
    st_tag       = dw_addr[LB+IDX_W +: TAG_W];
    hit_c        = (state_q == IDLE) && req && valid_q[la_idx] && (tag_q[la_idx] == la_tag);
    miss_start_c = (state_q == IDLE) && req && !hit_c && !Res && !flush_c;
    fill_idx     = (state_q == FILL) ? miss_idx_q : la_idx;
    fill_tag     = (state_q == FILL) ? miss_tag_q : la_tag;
    store_fill_c = we && (st_idx == fill_idx) && (st_tag == fill_tag);
    dout         = hit_c ? data_q[{la_idx, la_off}] : 32'h0;
    fetch        = !Res && !flush_c && ((state_q == FILL) || miss_start_c);
    if (Res)
      addr_out = '0;
    else if (state_q == FILL)
      addr_out = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
    else
      addr_out = {la[ADDR_W-1:LB], LB'(0)};
  end

  assign unused_c = ^{la[1:0], dw_addr[1:0]};

  // Next-state: snoop invalidation, fill sequencing and kill tracking
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    kill_d     = kill_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    wr_en      = 1'b0;
    tag_wr     = 1'b0;
    wr_idx     = miss_idx_q;
    wr_word    = cnt_q;

    if (we && valid_q[st_idx] && (tag_q[st_idx] == st_tag))
      valid_d[st_idx] = 1'b0;

    if (miss_start_c) begin
      miss_tag_d      = la_tag;
      miss_idx_d      = la_idx;
      valid_d[la_idx] = 1'b0;
      wr_en           = 1'b1;
      tag_wr          = 1'b1;
      wr_idx          = la_idx;
      wr_word         = '0;
      kill_d          = store_fill_c;
      cnt_d           = OFF_W'(1);
      state_d         = FILL;
    end else if (state_q == FILL) begin
      wr_en  = 1'b1;
      cnt_d  = cnt_q + OFF_W'(1);
      kill_d = kill_q || store_fill_c;
      if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
        valid_d[miss_idx_q] = !(kill_q || store_fill_c);
        kill_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end

    // Flush wins over everything, including a completing fill
    if (flush_c) begin
      valid_d = '0;
      state_d = IDLE;
      cnt_d   = '0;
      kill_d  = 1'b0;
      wr_en   = 1'b0;
      tag_wr  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Res) begin
    if (Res) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      kill_q     <= 1'b0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      kill_q     <= kill_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Tag and data arrays carry no reset; validity lives in valid_q only
  always_ff @(posedge clk) begin
    if (wr_en)
      data_q[{wr_idx, wr_word}] <= din;
    if (tag_wr)
      tag_q[wr_idx] <= la_tag;
  end

endmodule

// File: tb/tb_srm_icache.sv
// Bench for srm_icache: directed scenarios with literal checks plus a randomized run
// compared every cycle against a line-level behavioural model.
module tb_srm_icache;
  localparam int LW = 4;
  localparam int NL = 64;
  localparam int LINE_BYTES = 4 * LW;

  logic        clk = 1'b0;
  logic        res, req, we, jmp;
  logic [23:0] addr, dw_addr, jmp_addr, addr_out;
  logic [31:0] din, dout, salt;
  logic        fetch;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: per-line valid/tag/words and the fill in flight
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  logic [31:0] m_data  [NL][LW];
  int          fill_left;
  int unsigned fill_base;
  bit          killed;

  srm_icache dut (
    .clk(clk), .Res(res), .req(req), .we(we), .addr(addr), .dw_addr(dw_addr),
    .din(din), .jmp(jmp), .jmp_addr(jmp_addr), .addr_out(addr_out), .dout(dout), .fetch(fetch)
  );

  always #5 clk = ~clk;

  // Asynchronous memory: content is address xor a changeable salt
  assign din = {8'h00, addr_out} ^ salt;

  function automatic logic [31:0] mem(input int unsigned a);
    return 32'(a) ^ salt;
  endfunction

  function automatic int unsigned line_of(input int unsigned a);
    return a / LINE_BYTES;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare against the model, advance the model, then move to the next negedge
  task automatic cycle();
    int unsigned la, ln, idx, tg, off, sln, sidx, exp_a;
    bit hit, exp_f;
    logic [31:0] exp_d;
    la  = jmp ? int'(jmp_addr) : int'(addr);
    ln  = line_of(la);
    idx = ln % NL;
    tg  = ln / NL;
    off = (la / 4) % LW;
    hit = 0;
    if (res) begin
      exp_f = 0; exp_a = 0; exp_d = 0;
    end else if (fill_left > 0) begin
      exp_f = 1; exp_a = fill_base + 4 * (LW - fill_left); exp_d = 0;
    end else begin
      hit   = req && m_valid[idx] && m_tag[idx] == tg;
      exp_f = req && !hit;
      exp_a = ln * LINE_BYTES;
      exp_d = hit ? m_data[idx][off] : 32'h0;
    end
    chk("fetch", 32'(fetch), 32'(exp_f));
    chk("addr_out", 32'(addr_out), exp_a);
    chk("dout", dout, exp_d);

    if (res) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      fill_left = 0;
      killed = 0;
    end else begin
      sln  = line_of(dw_addr);
      sidx = sln % NL;
      if (we && m_valid[sidx] && m_tag[sidx] == sln / NL) m_valid[sidx] = 0;
      if (exp_f && fill_left == 0) begin
        fill_base = ln * LINE_BYTES;
        fill_left = LW;
        killed = 0;
        m_valid[idx] = 0;
        m_tag[idx] = tg;
      end
      if (exp_f) begin
        if (we && sln == line_of(fill_base)) killed = 1;
        m_data[line_of(fill_base) % NL][LW - fill_left] = mem(exp_a);
        fill_left--;
        if (fill_left == 0) m_valid[line_of(fill_base) % NL] = !killed;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input bit r, input bit rq, input int unsigned a);
    res = r; req = rq; addr = 24'(a); jmp = 0; jmp_addr = 0; we = 0; dw_addr = 0;
    #1;
  endtask

  task automatic fill_lit(input int unsigned base);
    for (int i = 0; i < LW; i++) begin
      chk("fill_fetch", 32'(fetch), 32'd1);
      chk("fill_addr", 32'(addr_out), 32'(base + 4 * i));
      cycle();
      #1;
    end
  endtask

  initial begin
    fill_left = 0; killed = 0; fill_base = 0; salt = 0;
    foreach (m_valid[i]) begin m_valid[i] = 0; m_tag[i] = 0; end
    set_in(1, 0, 0);
    @(negedge clk); #1;
    chk("rst_fetch", 32'(fetch), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_dout", dout, 32'd0);
    cycle();

    // Miss on 0x100, fill, then hit
    set_in(0, 1, 24'h000100);
    fill_lit(24'h100);
    chk("hit100_fetch", 32'(fetch), 32'd0);
    chk("hit100_dout", dout, 32'h00000100);
    cycle();
    set_in(0, 1, 24'h000108);
    chk("hit108_fetch", 32'(fetch), 32'd0);
    chk("hit108_dout", dout, 32'h00000108);
    cycle();

    // Conflict: 0x1100 evicts 0x100
    set_in(0, 1, 24'h001100);
    fill_lit(24'h1100);
    chk("hit1100_dout", dout, 32'h00001100);
    cycle();
    set_in(0, 1, 24'h000100);
    fill_lit(24'h100);

    // Store snoop on a hit line: served now, miss next
    we = 1; dw_addr = 24'h000104; #1;
    chk("snoop_hit_dout", dout, 32'h00000100);
    cycle();
    set_in(0, 1, 24'h000100);
    fill_lit(24'h100);

    // Store into the line being filled kills it
    set_in(0, 1, 24'h000200);
    cycle();
    we = 1; dw_addr = 24'h000208; #1;
    cycle();
    set_in(0, 1, 24'h000200);
    cycle(); cycle(); #1;
    fill_lit(24'h200);

    // Jump target takes precedence over addr
    set_in(0, 1, 24'h000300);
    jmp = 1; jmp_addr = 24'h000100; #1;
    chk("jmp_fetch", 32'(fetch), 32'd0);
    chk("jmp_dout", dout, 32'h00000100);
    cycle();

    // Reset mid-fill
    set_in(0, 1, 24'h000300);
    cycle(); cycle();
    res = 1; #1;
    chk("rst_mid_fetch", 32'(fetch), 32'd0);
    cycle();
    set_in(0, 1, 24'h000300);
    fill_lit(24'h300);
    set_in(0, 1, 24'h000100);
    fill_lit(24'h100);

    // Randomized traffic over a small, conflict-heavy address pool
    for (int n = 0; n < 3000; n++) begin
      res      = ($urandom_range(499) == 0);
      req      = ($urandom_range(3) != 0);
      addr     = 24'(($urandom_range(3) << 10) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2));
      jmp      = ($urandom_range(5) == 0);
      jmp_addr = 24'(($urandom_range(3) << 10) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2));
      we       = ($urandom_range(7) == 0);
      dw_addr  = 24'(($urandom_range(3) << 10) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2));
      if ($urandom_range(199) == 0) salt = $urandom;
      #1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
